// File: rtl/imem_load_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter_if
// Bundles the three buses that meet at the instruction-memory arbiter:
//   fetch_* : core fetch path (byte PC in, grant/response out)
//   ld_*    : boot/debug program loader (session control + word stream)
//   mem_*   : single-port synchronous IMEM (1-cycle read latency)
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding logic (core, loader, IMEM) or a testbench
// ---------------------------------------------------------------------------
interface imem_load_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;
    logic              fetch_err;
    logic              core_stall;

    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_busy;
    logic              ld_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, core_stall,
        input  ld_start, ld_base, ld_count, ld_valid, ld_data,
        output ld_ready, ld_busy, ld_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata, fetch_err, core_stall,
        output ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  ld_ready, ld_busy, ld_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_load_arbiter.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter
// Owns the single IMEM port and shares it between core instruction fetches
// (reads) and a program loader (writes). The loader has priority: while a
// load session runs, fetches are held off and the core is stalled.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imem_load_arbiter_if.slave (fetch_*, ld_*, mem_* groups)
//
// State table:
//   IDLE | fetches granted; ld_start opens a session
//   LOAD | loader words written to IMEM; fetches held off
// ---------------------------------------------------------------------------
module imem_load_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    imem_load_arbiter_if.slave     bus
);

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic              done_q, done_d;

    logic              fetch_gnt;
    logic              ld_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic [ADDR_W-1:0] fetch_waddr;
    logic              addr_err;

    assign fetch_waddr = bus.fetch_addr[ADDR_W+1:2];
    // Anything above the IMEM byte range, or not word aligned, is an error.
    assign addr_err = (bus.fetch_addr[1:0] != 2'b00) ||
                      ((bus.fetch_addr >> (ADDR_W + 2)) != 32'd0);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        done_d      = 1'b0;
        fetch_gnt   = 1'b0;
        ld_ready    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = fetch_waddr;
        mem_wdata   = '0;

        // Combinational port outputs are held quiet during reset so a
        // session aborted mid-beat cannot issue a stray write.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (bus.ld_start) begin
                        if (bus.ld_count == '0) begin
                            done_d = 1'b1;
                        end else begin
                            base_d      = bus.ld_base;
                            index_d     = '0;
                            remaining_d = bus.ld_count;
                            state_d     = LOAD;
                        end
                    end else if (bus.fetch_req) begin
                        // Bad addresses are still granted so the core gets
                        // an error response instead of stalling forever.
                        fetch_gnt = 1'b1;
                        mem_en    = ~addr_err;
                        rvalid_d  = 1'b1;
                        err_d     = addr_err;
                    end
                end
                LOAD: begin
                    ld_ready  = 1'b1;
                    mem_addr  = base_q + index_q;
                    mem_wdata = bus.ld_data;
                    if (bus.ld_valid) begin
                        mem_en      = 1'b1;
                        mem_we      = 1'b1;
                        index_d     = index_q + ADDR_W'(1);
                        remaining_d = remaining_q - (ADDR_W+1)'(1);
                        if (remaining_q == (ADDR_W+1)'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            index_q     <= '0;
            remaining_q <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    // IMEM data arrives one cycle after the grant, so the response word is
    // steered straight from mem_rdata rather than re-registered.
    assign bus.fetch_rdata  = (rvalid_q && !err_q) ? bus.mem_rdata : '0;
    assign bus.fetch_rvalid = rvalid_q;
    assign bus.fetch_err    = err_q;
    assign bus.fetch_gnt    = fetch_gnt;
    assign bus.core_stall   = bus.fetch_req & ~fetch_gnt;
    assign bus.ld_ready     = ld_ready;
    assign bus.ld_busy      = (state_q == LOAD);
    assign bus.ld_done      = done_q;
    assign bus.mem_en       = mem_en;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;

endmodule
